// File: rtl/mux4_pkg.sv
// rtl/mux4_pkg.sv - shared types and constants for the 4-to-1 mux serial driver
package mux4_pkg;

    // Sequencer states: IDLE waits for a word, SHIFT walks the mux select.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Mux select codes, one per data input.
    localparam logic [1:0] SEL_U = 2'b00;
    localparam logic [1:0] SEL_V = 2'b01;
    localparam logic [1:0] SEL_W = 2'b10;
    localparam logic [1:0] SEL_X = 2'b11;

    // Largest supported dwell per select value.
    localparam int DWELL_MAX = 16;

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - per-select dwell counter that saturates at DWELL-1
//
// Ports:
//   clk    in  : clock
//   resetn in  : asynchronous active-low reset
//   clear  in  : restart the count at zero (priority over hold)
//   hold   in  : freeze the count
//   done   out : count has reached DWELL-1
module dwell_timer
    import mux4_pkg::*;
#(
    parameter int DWELL = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic hold,
    output logic done
);

    // Out-of-range parameters are pulled into 1..DWELL_MAX.
    localparam int DW = (DWELL < 1) ? 1 : ((DWELL > DWELL_MAX) ? DWELL_MAX : DWELL);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    logic [CW-1:0] cnt;

    // Stopping at LAST is what keeps ser_valid asserted under backpressure.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (!hold && !done) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign done = (cnt == LAST);

endmodule

// File: rtl/mux4_serial_driver.sv
// rtl/mux4_serial_driver.sv - drives a 4-to-1 mux and serialises its output LSB first
//
// Ports:
//   clk, resetn                  : clock, asynchronous active-low reset
//   in_valid, in_ready, in_data  : 4-bit word handshake (bit0->u .. bit3->x)
//   mux_s, mux_u..mux_x          : mux select and data inputs
//   mux_m                        : mux output fed back in
//   ser_valid, ser_ready,
//   ser_bit, ser_last            : serial output stream, last on select 11
//   err                          : sticky flag, mux output disagreed with the word
module mux4_serial_driver
    import mux4_pkg::*;
#(
    parameter int DWELL = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic [1:0] mux_s,
    output logic       mux_u,
    output logic       mux_v,
    output logic       mux_w,
    output logic       mux_x,
    input  logic       mux_m,
    output logic       ser_valid,
    input  logic       ser_ready,
    output logic       ser_bit,
    output logic       ser_last,
    output logic       err
);

    state_t     state;
    state_t     state_nx;
    logic [3:0] word;
    logic [1:0] idx;
    logic       err_r;
    logic       done;
    logic       accept;
    logic       xfer;

    dwell_timer #(
        .DWELL(DWELL)
    ) u_dwell (
        .clk   (clk),
        .resetn(resetn),
        .clear (accept || xfer),
        .hold  (state == IDLE),
        .done  (done)
    );

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid = done;
                if (done && ser_ready && (idx == SEL_X)) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign accept   = in_valid && in_ready;
    assign xfer     = ser_valid && ser_ready;
    assign ser_bit  = ser_valid && mux_m;
    assign ser_last = ser_valid && (idx == SEL_X);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // idx stops at SEL_X on the final bit instead of wrapping, so mux_s
    // keeps showing the last select while the block sits in IDLE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            word  <= '0;
            idx   <= SEL_U;
            err_r <= 1'b0;
        end else if (accept) begin
            word <= in_data;
            idx  <= SEL_U;
        end else if (xfer) begin
            if (mux_m != word[idx]) begin
                err_r <= 1'b1;
            end
            if (idx != SEL_X) begin
                idx <= idx + 2'd1;
            end
        end
    end

    assign mux_s = idx;
    assign mux_u = word[0];
    assign mux_v = word[1];
    assign mux_w = word[2];
    assign mux_x = word[3];
    assign err   = err_r;

endmodule

// File: doc/mux4_serial_driver.md
# mux4_serial_driver

Upstream sequencer for the 1-bit 4-to-1 mux (`one_bit_4to1mux` / `one_bit_4to1muxV2`). It accepts a 4-bit word over a valid/ready handshake and drives the word onto the mux data inputs. It then steps the mux select 00→01→10→11 and emits the mux output as an LSB-first serial stream with valid/ready/last. Each emitted bit is checked against the latched word, and any mismatch raises a sticky error flag.

## Interface
Parameters:
- `DWELL`, 1: cycles each select value is held before its bit is offered; legal range 1..16.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: block can accept a word.
- `in_data` in 4: word to send; bit0→u, bit1→v, bit2→w, bit3→x.
- `mux_s` out 2: mux select.
- `mux_u`, `mux_v`, `mux_w`, `mux_x` out 1 each: mux data inputs.
- `mux_m` in 1: mux output.
- `ser_valid` out 1: `ser_bit` is offered.
- `ser_ready` in 1: downstream accepts `ser_bit`.
- `ser_bit` out 1: equals `mux_m` when `ser_valid` is high, else 0.
- `ser_last` out 1: high with `ser_valid` on the select=11 bit.
- `err` out 1: sticky mismatch flag.

## Operation
- FSM states:
  - IDLE: `in_ready`=1, `ser_valid`=0.
  - SHIFT: `in_ready`=0.
- Transitions:
  - IDLE→SHIFT on `in_valid`&&`in_ready`.
    - Latches `in_data` into `word`.
    - Clears `idx` (2 b) and `dwell` counter.
  - SHIFT→IDLE on the transfer where `idx`==3.
- Outputs in SHIFT:
  - `mux_s`=`idx`; `mux_u..x`=`word[0..3]`.
  - `ser_valid`=1 when `dwell`==DWELL-1.
- Transfer = `ser_valid`&&`ser_ready`:
  - `idx` increments, `dwell` clears.
  - With `ser_valid` low, `dwell` increments.
  - With `ser_valid` high and `ser_ready` low, `dwell` saturates at DWELL-1 and `idx`, `word` and `mux_*` all hold.
- Error check: on each transfer, if `mux_m` != `word[idx]`, `err` sets. `err` clears only on reset.
- In IDLE, `mux_*` keep their last driven values; only `ser_*` are forced low.
- `in_valid` during SHIFT is ignored; no word is lost because `in_ready`=0.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE; `word`=0, `idx`=0, `dwell`=0.
  - `mux_s`=00, `mux_u..x`=0.
  - `ser_valid`=0, `ser_bit`=0, `ser_last`=0, `err`=0.
  - `in_ready`=1.
- Latency: word accepted at edge k. First `ser_valid` in cycle k+DWELL, counted after edge k.
- With `ser_ready` held high, the four bits occupy cycles k+DWELL .. k+4·DWELL. `in_ready` returns high in the cycle after the last transfer (one-cycle bubble between words).
- `ser_bit` and `ser_valid` are combinational from registered state plus `mux_m`. The mux path must settle within one cycle.
- `dwell` counter width is max(1, $clog2(DWELL)). For DWELL=1, `ser_valid` is high every SHIFT cycle.
- Reset asserted mid-SHIFT aborts the word with no further `ser_valid`.

## Structure
- Shared package `mux4_pkg`:
  - state enum `{IDLE, SHIFT}`.
  - select constants `SEL_U`=00 .. `SEL_X`=11.
  - `DWELL_MAX`=16.
- One sub-module, `dwell_timer`:
  - inputs: `clk`, `resetn`, `clear`, `hold`.
  - output: `done`.
  - parameter: `DWELL`.
- Top level holds the FSM, `word`/`idx` registers and the error checker.

## Test plan
- DWELL=1, `ser_ready`=1, word 4'b0001:
  - `ser_bit` = 1,0,0,0 over 4 cycles; `mux_s` = 00,01,10,11.
  - `ser_last` only on the 4th bit; `err`=0.
- DWELL=1, word 4'b1011: `ser_bit` = 1,1,0,1; `in_ready` low for 4 cycles, then high.
- DWELL=3, word 4'b1010:
  - `ser_valid` high on every 3rd cycle; bits 0,1,0,1.
  - Total 12 cycles from accept to last transfer.
- Backpressure: word 4'b0110, `ser_ready` low for 5 cycles on bit 1.
  - `ser_valid` stays high and `ser_bit`=1 throughout; `mux_s` holds 01.
  - Stream resumes 1,0 afterwards.
- Fault: `mux_m` forced inverted, word 4'b0101 → `err` rises on the first transfer and stays 1 through a following clean word.
- `resetn` pulsed low mid-word 4'b1111 after 2 bits:
  - All outputs go to reset values immediately; `in_ready`=1.
  - A next word 4'b0011 streams 1,1,0,0 correctly.
